// File: rtl/gdu_pkg.sv
// -----------------------------------------------------------------------------
// gdu_pkg
// Shared types and default widths for the graphics drawing unit memory
// arbiter and its read-owner tag pipeline.
//   owner_t     : who issued a RAM read (none / pixel fetch / CPU)
//   arb_state_t : arbiter FSM state
// -----------------------------------------------------------------------------
package gdu_pkg;

  localparam int GDU_ADDR_W   = 12;
  localparam int GDU_DATA_W   = 32;
  localparam int GDU_RAM_LAT  = 2;
  localparam int GDU_MAX_WAIT = 16;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_CPU   = 2'd2
  } owner_t;

  typedef enum logic {
    IDLE   = 1'b0,
    CPU_RD = 1'b1
  } arb_state_t;

endpackage : gdu_pkg

// File: rtl/gdu_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// gdu_rd_tag_pipe
// RAM_LAT-deep shift register of read-owner tags. A tag pushed in the cycle a
// read address is issued appears on tag_o in the cycle its RAM data is valid.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low clear (all stages to OWN_NONE)
//   tag_i   : owner of the read issued this cycle (OWN_NONE if none)
//   tag_o   : owner of the read whose data is on RAM_Q this cycle
// -----------------------------------------------------------------------------
module gdu_rd_tag_pipe
  import gdu_pkg::*;
#(
  parameter int RAM_LAT = GDU_RAM_LAT
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [RAM_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RAM_LAT-1];

endmodule : gdu_rd_tag_pipe

// File: rtl/gdu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// gdu_mem_arbiter
// Shares the single frame/sprite RAM port between the CPU Avalon-MM slave and
// the pixel-fetch engine. Fetch has priority (scan-out deadline); the CPU is
// stalled with AVL_WAITREQUEST. Reads are tagged with their owner so returning
// RAM_Q data is steered to the right requester.
//
// Optional feature: define GDU_ARB_STARVE_EN to enable the anti-starvation
// counter. After MAX_WAIT stalled cycles the CPU wins the next arbitration over
// FETCH_REQ. Without the macro, fetch priority is strict.
//
// Ports:
//   CLK, RESET_N            : clock, async active-low reset
//   AVL_CS/READ/WRITE       : Avalon request qualifiers (READ&WRITE = write)
//   AVL_BYTE_EN/ADDR/WRITEDATA : CPU write byte enables, address, data
//   AVL_READDATA            : CPU read data (holds last value between reads)
//   AVL_WAITREQUEST         : low only in the cycle a CPU access completes
//   FETCH_REQ/ADDR          : fetch read request and address
//   FETCH_GNT               : fetch read issued this cycle
//   FETCH_RVALID/RDATA      : fetch read data return
//   RAM_ADDR/BYTEEN/WDATA/WREN : RAM port controls
//   RAM_Q                   : RAM read data, RAM_LAT cycles after address
//
// State table:
//   state  | meaning
//   IDLE   | CPU requests may be accepted
//   CPU_RD | CPU read in flight; no new CPU request until its data returns
// -----------------------------------------------------------------------------
module gdu_mem_arbiter
  import gdu_pkg::*;
#(
  parameter int ADDR_W   = GDU_ADDR_W,
  parameter int DATA_W   = GDU_DATA_W,
  parameter int RAM_LAT  = GDU_RAM_LAT,
  parameter int MAX_WAIT = GDU_MAX_WAIT
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  output logic                AVL_WAITREQUEST,
  input  logic                FETCH_REQ,
  input  logic [ADDR_W-1:0]   FETCH_ADDR,
  output logic                FETCH_GNT,
  output logic                FETCH_RVALID,
  output logic [DATA_W-1:0]   FETCH_RDATA,
  output logic [ADDR_W-1:0]   RAM_ADDR,
  output logic [DATA_W/8-1:0] RAM_BYTEEN,
  output logic [DATA_W-1:0]   RAM_WDATA,
  output logic                RAM_WREN,
  input  logic [DATA_W-1:0]   RAM_Q
);

  arb_state_t        state_q, state_d;
  owner_t            tag_push, tag_out;
  logic              cpu_req, cpu_wr, starve_ovr;
  logic              gnt_fetch, gnt_cpu;
  logic              cpu_done, fetch_done;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Simultaneous READ and WRITE is treated as a write.
  assign cpu_req = AVL_CS & (AVL_READ | AVL_WRITE) & (state_q == IDLE);
  assign cpu_wr  = AVL_WRITE;

`ifdef GDU_ARB_STARVE_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_ovr = cpu_req & (starve_cnt_q == CNT_MAX);

  // Reaching CNT_MAX forces a CPU grant, which clears the count, so the
  // increment can never wrap.
  assign starve_cnt_d = (cpu_req & ~gnt_cpu) ? CNT_W'(starve_cnt_q + 1'b1) : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_ovr = 1'b0;
`endif

  assign gnt_fetch = FETCH_REQ & ~starve_ovr;
  assign gnt_cpu   = cpu_req & (~FETCH_REQ | starve_ovr);

  gdu_rd_tag_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_tag_pipe (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .tag_i  (tag_push),
    .tag_o  (tag_out)
  );

  assign cpu_done   = (tag_out == OWN_CPU);
  assign fetch_done = (tag_out == OWN_FETCH);

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_cpu && !cpu_wr) state_d = CPU_RD;
      CPU_RD:  if (cpu_done)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and RAM port steering
  always_comb begin
    RAM_ADDR        = FETCH_ADDR;
    RAM_WREN        = 1'b0;
    RAM_BYTEEN      = '0;
    RAM_WDATA       = AVL_WRITEDATA;
    FETCH_GNT       = gnt_fetch;
    tag_push        = OWN_NONE;
    if (gnt_fetch) begin
      tag_push = OWN_FETCH;
    end else if (gnt_cpu) begin
      RAM_ADDR = AVL_ADDR;
      if (cpu_wr) begin
        RAM_WREN   = 1'b1;
        RAM_BYTEEN = AVL_BYTE_EN;
      end else begin
        tag_push = OWN_CPU;
      end
    end
    AVL_WAITREQUEST = ~((gnt_cpu & cpu_wr) | cpu_done);
    FETCH_RVALID    = fetch_done;
    FETCH_RDATA     = fetch_done ? RAM_Q : '0;
    AVL_READDATA    = cpu_done ? RAM_Q : rdata_q;
  end

  // Holding register so AVL_READDATA keeps the last CPU read result.
  assign rdata_d = cpu_done ? RAM_Q : rdata_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

endmodule : gdu_mem_arbiter

// File: tb/tb_gdu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gdu_mem_arbiter
// Random and directed stimulus for gdu_mem_arbiter against a transaction-level
// reference: a shadow memory, the fetch-priority grant rule and a per-owner
// queue of expected read returns. Define GDU_ARB_STARVE_EN to also exercise
// the anti-starvation override.
// -----------------------------------------------------------------------------
module tb_gdu_mem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int RAM_LAT  = 2;
  localparam int MAX_WAIT = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              AVL_CS, AVL_READ, AVL_WRITE;
  logic [BE_W-1:0]   AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [DATA_W-1:0] AVL_WRITEDATA;
  logic [DATA_W-1:0] AVL_READDATA;
  logic              AVL_WAITREQUEST;
  logic              FETCH_REQ;
  logic [ADDR_W-1:0] FETCH_ADDR;
  logic              FETCH_GNT, FETCH_RVALID;
  logic [DATA_W-1:0] FETCH_RDATA;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [BE_W-1:0]   RAM_BYTEEN;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WREN;
  logic [DATA_W-1:0] RAM_Q;

  always #5 CLK = ~CLK;

  gdu_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RAM_LAT  (RAM_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .AVL_CS          (AVL_CS),
    .AVL_READ        (AVL_READ),
    .AVL_WRITE       (AVL_WRITE),
    .AVL_BYTE_EN     (AVL_BYTE_EN),
    .AVL_ADDR        (AVL_ADDR),
    .AVL_WRITEDATA   (AVL_WRITEDATA),
    .AVL_READDATA    (AVL_READDATA),
    .AVL_WAITREQUEST (AVL_WAITREQUEST),
    .FETCH_REQ       (FETCH_REQ),
    .FETCH_ADDR      (FETCH_ADDR),
    .FETCH_GNT       (FETCH_GNT),
    .FETCH_RVALID    (FETCH_RVALID),
    .FETCH_RDATA     (FETCH_RDATA),
    .RAM_ADDR        (RAM_ADDR),
    .RAM_BYTEEN      (RAM_BYTEEN),
    .RAM_WDATA       (RAM_WDATA),
    .RAM_WREN        (RAM_WREN),
    .RAM_Q           (RAM_Q)
  );

  function automatic logic [31:0] init_pat(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- RAM model (environment) ----------------
  bit [31:0] mem    [DEPTH];
  bit        mem_wr [DEPTH];
  bit [31:0] q_pipe [RAM_LAT];

  always @(posedge CLK) begin
    logic [31:0] cur;
    cur = mem_wr[RAM_ADDR] ? mem[RAM_ADDR] : init_pat(RAM_ADDR);
    if (RAM_WREN) begin
      for (int b = 0; b < BE_W; b++)
        if (RAM_BYTEEN[b]) cur[8*b +: 8] = RAM_WDATA[8*b +: 8];
      mem[RAM_ADDR]    <= cur;
      mem_wr[RAM_ADDR] <= 1'b1;
    end
    q_pipe[0] <= mem_wr[RAM_ADDR] ? mem[RAM_ADDR] : init_pat(RAM_ADDR);
    for (int i = 1; i < RAM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end

  assign RAM_Q = q_pipe[RAM_LAT-1];

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        fq[$];
  exp_t        cq[$];
  bit [31:0]   sh_mem [DEPTH];
  bit          sh_wr  [DEPTH];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          m_busy   = 1'b0;
  int          m_due    = 0;
  int          wait_cnt = 0;
  logic [31:0] last_rd  = '0;
  int          fmode    = 0;
  int          fseq     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] sh_read(input logic [ADDR_W-1:0] a);
    return sh_wr[a] ? sh_mem[a] : init_pat(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event-missing/extra expected clean (cycle %0d)", name, cyc);
  endtask

  // ---------------- predictor: grant rule, port checks, expected pushes ----------------
  initial begin
    forever begin
      bit cpu_req_m, ovr, exp_fg, exp_cg, done_m;
      exp_t e;
      logic [31:0] cur;
      @(negedge CLK);
      if (!RESET_N) begin
        fq.delete();
        cq.delete();
        m_busy   = 1'b0;
        wait_cnt = 0;
        last_rd  = '0;
        chk("rst_fetch_gnt", FETCH_GNT, 1'b0);
        chk("rst_rvalid", FETCH_RVALID, 1'b0);
        chk("rst_waitreq", AVL_WAITREQUEST, 1'b1);
        chk("rst_wren", RAM_WREN, 1'b0);
        chk("rst_fetch_rdata", FETCH_RDATA, 32'h0);
        chk("rst_avl_rdata", AVL_READDATA, 32'h0);
      end else begin
        cpu_req_m = AVL_CS && (AVL_READ || AVL_WRITE) && !m_busy;
        ovr = 1'b0;
`ifdef GDU_ARB_STARVE_EN
        ovr = cpu_req_m && (wait_cnt == MAX_WAIT);
`endif
        exp_fg = FETCH_REQ && !ovr;
        exp_cg = cpu_req_m && (!FETCH_REQ || ovr);
        done_m = m_busy && (cyc == m_due);
        chk("fetch_gnt", FETCH_GNT, exp_fg);
        chk("waitreq", AVL_WAITREQUEST, !((exp_cg && AVL_WRITE) || done_m));
        chk("ram_wren", RAM_WREN, exp_cg && AVL_WRITE);
        if (exp_fg) begin
          chk("ram_addr_fetch", RAM_ADDR, FETCH_ADDR);
          e.data = sh_read(FETCH_ADDR);
          e.due  = cyc + RAM_LAT;
          fq.push_back(e);
        end else if (exp_cg) begin
          chk("ram_addr_cpu", RAM_ADDR, AVL_ADDR);
          if (AVL_WRITE) begin
            chk("ram_byteen", RAM_BYTEEN, AVL_BYTE_EN);
            chk("ram_wdata", RAM_WDATA, AVL_WRITEDATA);
            cur = sh_read(AVL_ADDR);
            for (int b = 0; b < BE_W; b++)
              if (AVL_BYTE_EN[b]) cur[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
            sh_mem[AVL_ADDR] = cur;
            sh_wr[AVL_ADDR]  = 1'b1;
          end else begin
            e.data = sh_read(AVL_ADDR);
            e.due  = cyc + RAM_LAT;
            cq.push_back(e);
            m_busy = 1'b1;
            m_due  = cyc + RAM_LAT;
          end
        end else begin
          chk("ram_byteen_idle", RAM_BYTEEN, '0);
        end
        if (done_m) m_busy = 1'b0;
        wait_cnt = (cpu_req_m && !exp_cg) ? wait_cnt + 1 : 0;
      end
    end
  end

  // ---------------- monitor: pops expected returns when the DUT presents them ----------------
  initial begin
    forever begin
      exp_t e;
      @(negedge CLK);
      if (RESET_N) begin
        if (FETCH_RVALID) begin
          if (fq.size() == 0) flag("fetch_rvalid_unexpected");
          else begin
            e = fq.pop_front();
            chk("fetch_rdata", FETCH_RDATA, e.data);
            chk("fetch_latency", cyc, e.due);
          end
        end else if (fq.size() > 0 && fq[0].due <= cyc) begin
          void'(fq.pop_front());
          flag("fetch_rvalid_missing");
        end
        if (!AVL_WAITREQUEST && cq.size() > 0) begin
          e = cq.pop_front();
          chk("cpu_rdata", AVL_READDATA, e.data);
          chk("cpu_rd_latency", cyc, e.due);
          last_rd = e.data;
        end else begin
          if (cq.size() > 0 && cq[0].due <= cyc) begin
            void'(cq.pop_front());
            flag("cpu_rd_missing");
          end
          chk("avl_rdata_hold", AVL_READDATA, last_rd);
        end
      end
    end
  end

  // ---------------- fetch engine driver ----------------
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (fmode)
        1: begin
          FETCH_REQ  = 1'($urandom_range(0, 1));
          FETCH_ADDR = ADDR_W'($urandom_range(0, 31));
        end
        2: begin
          FETCH_REQ  = 1'b1;
          FETCH_ADDR = ADDR_W'($urandom_range(0, 31));
        end
        3: begin
          FETCH_REQ  = 1'b1;
          FETCH_ADDR = ADDR_W'(fseq);
          fseq++;
        end
        default: FETCH_REQ = 1'b0;
      endcase
    end
  end

  // Issue one CPU access at the current cycle; hold until WAITREQUEST drops.
  task automatic cpu_xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [BE_W-1:0] be, output int waited, output logic [31:0] rd);
    bit done;
    AVL_CS = 1'b1; AVL_READ = !wr; AVL_WRITE = wr;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    waited = 0; done = 1'b0; rd = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (!AVL_WAITREQUEST) begin
        done = 1'b1;
        rd   = AVL_READDATA;
      end else begin
        waited++;
      end
    end
    if (!done) flag("cpu_timeout");
    @(posedge CLK);
    #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int          w, ngnt, nrv;
    logic [31:0] rd;
    RESET_N = 1'b0;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_BYTE_EN = '0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    FETCH_REQ = 1'b0; FETCH_ADDR = '0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    // uncontended write then read-back
    cpu_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, w, rd);
    chk("wr_wait_cycles", w, 0);
    cpu_xfer(1'b0, 12'h010, 32'h0, 4'h0, w, rd);
    chk("rd_wait_cycles", w, RAM_LAT);
    chk("rd_back_data", rd, 32'hDEADBEEF);

    // fetch burst 0x000..0x007
    @(posedge CLK);
    fseq = 0; fmode = 3;
    ngnt = 0; nrv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      ngnt += int'(FETCH_GNT);
      nrv  += int'(FETCH_RVALID);
      @(posedge CLK);
      if (i == 7) fmode = 0;
    end
    chk("burst_gnt_count", ngnt, 8);
    chk("burst_rvalid_count", nrv, 8);

    // CPU read contending with fetch for 5 cycles
    @(posedge CLK); fmode = 2;
    @(posedge CLK); #1;
    fork
      cpu_xfer(1'b0, 12'h010, 32'h0, 4'h0, w, rd);
      begin
        repeat (5) @(posedge CLK);
        fmode = 0;
      end
    join
    chk("contend_wait_cycles", w, 5 + RAM_LAT);

`ifdef GDU_ARB_STARVE_EN
    // fetch held permanently; CPU forced in after MAX_WAIT stalls
    @(posedge CLK); fmode = 2;
    @(posedge CLK); #1;
    cpu_xfer(1'b0, 12'h003, 32'h0, 4'h0, w, rd);
    chk("starve_wait_cycles", w, MAX_WAIT + RAM_LAT);
    @(posedge CLK); fmode = 0;
`endif

    // random interleaving of CPU reads/writes with random fetch traffic
    @(posedge CLK); fmode = 1;
    @(posedge CLK); #1;
    for (int n = 0; n < 40; n++) begin
      cpu_xfer(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), $urandom,
               BE_W'($urandom_range(0, 15)), w, rd);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    @(posedge CLK); fmode = 0;
    repeat (4) @(posedge CLK);

    // reset one cycle after a CPU read grant, with a fetch read in flight
    @(posedge CLK); fmode = 2;
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 12'h010;
    @(posedge CLK); fmode = 0;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_waitreq", AVL_WAITREQUEST, 1'b1);
      chk("post_rst_rvalid", FETCH_RVALID, 1'b0);
    end
    @(posedge CLK); #1;
    cpu_xfer(1'b1, 12'h020, 32'h1234_5678, 4'h3, w, rd);
    chk("post_rst_idle_write", w, 0);
    repeat (4) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gdu_mem_arbiter

// File: doc/gdu_mem_arbiter.md
# gdu_mem_arbiter

Single-port access arbiter for the graphics drawing unit's frame/sprite RAM. It shares one RAM port between two requesters: the CPU Avalon-MM slave and the pixel-fetch engine that feeds the VGA output path. Fetch has priority because of its scan-out deadline. CPU accesses are stalled with waitrequest, and an optional anti-starvation counter bounds how long a CPU access can be held off.

## Interface
- ADDR_W, 12, RAM word address width
- DATA_W, 32, RAM data width
- RAM_LAT, 2, RAM read latency in cycles (≥1), from address issue to valid RAM_Q
- MAX_WAIT, 16, CPU stall cycles before a forced CPU grant (used only with the macro in Configuration)

Ports:
- CLK  in  1  single clock for all logic
- RESET_N  in  1  asynchronous, active-low reset
- AVL_CS, AVL_READ, AVL_WRITE  in  1  Avalon request qualifiers
- AVL_BYTE_EN  in  DATA_W/8  write byte enables
- AVL_ADDR  in  ADDR_W  CPU word address
- AVL_WRITEDATA  in  DATA_W  CPU write data
- AVL_READDATA  out  DATA_W  CPU read data, valid when the read completes
- AVL_WAITREQUEST  out  1  high = current CPU request not accepted/completed
- FETCH_REQ  in  1  fetch read request
- FETCH_ADDR  in  ADDR_W  fetch address
- FETCH_GNT  out  1  fetch request issued this cycle
- FETCH_RVALID  out  1  FETCH_RDATA valid
- FETCH_RDATA  out  DATA_W  fetch read data
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_BYTEEN  out  DATA_W/8  RAM byte enables
- RAM_WDATA  out  DATA_W  RAM write data
- RAM_WREN  out  1  RAM write enable
- RAM_Q  in  DATA_W  RAM read data

## Operation
- cpu_req = AVL_CS & (AVL_READ | AVL_WRITE) & (state == IDLE). AVL_READ and AVL_WRITE both high: treat as a write.
- Grant each cycle, combinational:
  - FETCH_REQ set: fetch wins, unless the starvation override is active.
  - Otherwise cpu_req: CPU wins.
  - Otherwise: no grant.
- Idle port: RAM_ADDR = FETCH_ADDR, RAM_WREN = 0, RAM_BYTEEN = 0.
- Fetch grant: FETCH_GNT = 1; RAM_ADDR = FETCH_ADDR. Fetch reads are pipelined, one per cycle.
- CPU write grant: RAM_WREN = 1; RAM_ADDR/BYTEEN/WDATA = AVL_*; AVL_WAITREQUEST = 0 in the same cycle.
- CPU read grant: RAM_ADDR = AVL_ADDR; FSM moves IDLE → CPU_RD.
- Read-owner tracking: each issued read pushes an owner tag (NONE/FETCH/CPU) into a RAM_LAT-deep shift register.
  - Tag FETCH at the output: FETCH_RVALID = 1, FETCH_RDATA = RAM_Q.
  - Tag CPU at the output: AVL_READDATA = RAM_Q, AVL_WAITREQUEST = 0 for exactly that cycle; FSM returns CPU_RD → IDLE.
- FSM states: IDLE, CPU_RD.
  - In CPU_RD no new CPU request is accepted.
  - Fetch grants continue during CPU_RD.
- AVL_WAITREQUEST is 1 in every cycle not listed above, including when there is no request.
- AVL_READDATA holds its last value between reads.
- CPU deasserting AVL_CS during CPU_RD does not abort the read; it completes and its data is dropped by the master.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, tag pipe all NONE, starvation counter = 0.
  - FETCH_GNT = 0, FETCH_RVALID = 0, AVL_WAITREQUEST = 1, RAM_WREN = 0.
  - FETCH_RDATA = 0, AVL_READDATA = 0.
- Reset mid-read: in-flight tags are cleared; no RVALID and no read completion is produced afterwards.
- Fetch latency: FETCH_GNT in cycle t → FETCH_RVALID in cycle t+RAM_LAT.
- CPU write latency: 0 added cycles when uncontended.
- CPU read latency: request at t (uncontended) → WAITREQUEST low at t+RAM_LAT.
- FETCH_GNT and AVL_WAITREQUEST are combinational from the inputs.
- FETCH_RVALID, FETCH_RDATA, AVL_READDATA and the completion pulse align with the RAM_Q cycle.

## Configuration
- GDU_ARB_STARVE_EN defined:
  - A counter of width $clog2(MAX_WAIT+1) increments each cycle cpu_req is high and not granted.
  - The counter clears on a CPU grant or when cpu_req is low.
  - When it reaches MAX_WAIT, the CPU wins the next arbitration over FETCH_REQ; FETCH_GNT = 0 that cycle.
- Macro undefined: strict fetch priority; no counter logic. The CPU can be stalled indefinitely.

## Structure
- gdu_pkg: owner_t enum {OWN_NONE, OWN_FETCH, OWN_CPU}, arb_state_t {IDLE, CPU_RD}, default width constants.
- Sub-module gdu_rd_tag_pipe: parameterised RAM_LAT shift register of owner_t with async clear.

## Test plan
- Idle CPU write addr 0x010, data 0xDEADBEEF, byte-en 0xF → RAM_WREN=1 and WAITREQUEST=0 in the same cycle. A later read returns 0xDEADBEEF with WAITREQUEST low at t+2.
- Fetch back-to-back reads 0x000..0x007, 8 cycles → 8 consecutive FETCH_GNT, then 8 consecutive FETCH_RVALID with matching data, starting 2 cycles later.
- CPU and fetch request in the same cycle, macro off → fetch granted; CPU granted the first cycle FETCH_REQ drops.
- GDU_ARB_STARVE_EN, MAX_WAIT=16, FETCH_REQ held high, CPU read pending:
  - CPU is granted on the 17th cycle of waiting; FETCH_GNT=0 that cycle.
  - Fetch resumes the next cycle.
- CPU read interleaved with fetch reads → each RVALID/WAITREQUEST completion goes to the correct owner with the correct data.
- RESET_N pulsed low one cycle after a CPU read grant → no completion and no FETCH_RVALID afterwards. State is IDLE and WAITREQUEST=1.
